// File: rtl/alu_operand_select.sv
// Y86 execute-stage operand selector: picks ALU operands and function from icode/ifun and registers them.
// Build option ALU_SEL_IADDQ_EN adds iaddq (icode 0xC) as valC + valB.
module alu_operand_select #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valB,
  input  logic [DATA_W-1:0] valC,
  output logic              out_valid,
  output logic [DATA_W-1:0] aluA,
  output logic [DATA_W-1:0] aluB,
  output logic [1:0]        alufun
);

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
`ifdef ALU_SEL_IADDQ_EN
  localparam logic [3:0] I_IADDQ  = 4'hC;
`endif

  localparam logic [1:0] ALU_ADD = 2'd0;

  // Stack pointer adjustments are plain constants; the ALU does the add.
  localparam logic [DATA_W-1:0] CONST_P8 = {{(DATA_W-4){1'b0}}, 4'b1000};
  localparam logic [DATA_W-1:0] CONST_M8 = {{(DATA_W-4){1'b1}}, 4'b1000};

  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [1:0]        sel_fun;

  // Only the low two ifun bits select the op; OPq with ifun > 3 aliases silently.
  logic unused_ifun_hi;
  assign unused_ifun_hi = ^ifun[3:2];

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_fun = ALU_ADD;
    case (icode)
      I_RRMOVQ: sel_a = valA;
      I_IRMOVQ: sel_a = valC;
      I_RMMOVQ,
      I_MRMOVQ: begin
        sel_a = valC;
        sel_b = valB;
      end
      I_OPQ: begin
        sel_a   = valA;
        sel_b   = valB;
        sel_fun = ifun[1:0];
      end
      I_CALL,
      I_PUSHQ: begin
        sel_a = CONST_M8;
        sel_b = valB;
      end
      I_RET,
      I_POPQ: begin
        sel_a = CONST_P8;
        sel_b = valB;
      end
`ifdef ALU_SEL_IADDQ_EN
      I_IADDQ: begin
        sel_a = valC;
        sel_b = valB;
      end
`endif
      default: begin
        sel_a   = '0;
        sel_b   = '0;
        sel_fun = ALU_ADD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      aluA      <= '0;
      aluB      <= '0;
      alufun    <= ALU_ADD;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        aluA   <= sel_a;
        aluB   <= sel_b;
        alufun <= sel_fun;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_select.sv
// Bench for alu_operand_select: reference model from the instruction table plus literal expectations.
// Honours ALU_SEL_IADDQ_EN the same way the design build does.
module tb_alu_operand_select;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA;
  logic [W-1:0] valB;
  logic [W-1:0] valC;
  logic         out_valid;
  logic [W-1:0] aluA;
  logic [W-1:0] aluB;
  logic [1:0]   alufun;

  int checks   = 0;
  int failures = 0;

  alu_operand_select #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC),
    .out_valid(out_valid), .aluA(aluA), .aluB(aluB), .alufun(alufun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   f;
  } sel_t;

  // Instruction-table reference: which source feeds each operand.
  function automatic sel_t model(input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c);
    sel_t r;
    logic iadd;
`ifdef ALU_SEL_IADDQ_EN
    iadd = (ic == 4'hC);
`else
    iadd = 1'b0;
`endif
    if (ic inside {4'h2, 4'h6})               r.a = a;
    else if (ic inside {4'h3, 4'h4, 4'h5} || iadd) r.a = c;
    else if (ic inside {4'h8, 4'hA})          r.a = W'(0) - W'(8);
    else if (ic inside {4'h9, 4'hB})          r.a = W'(8);
    else                                      r.a = '0;
    r.b = (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB} || iadd) ? b : '0;
    r.f = (ic == 4'h6) ? 2'(fn % 4) : 2'd0;
    return r;
  endfunction

  logic         armed = 1'b0;
  logic         m_v;
  sel_t         m;

  always @(posedge clk) begin
    if (rst) begin
      m_v   = 1'b0;
      m.a   = '0;
      m.b   = '0;
      m.f   = 2'd0;
      armed = 1'b1;
    end else begin
      m_v = in_valid;
      if (in_valid) m = model(icode, ifun, valA, valB, valC);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (out_valid !== m_v || aluA !== m.a || aluB !== m.b || alufun !== m.f) begin
        failures++;
        $display("FAIL model_cmp t=%0t got v=%b a=%h b=%h f=%0d expected v=%b a=%h b=%h f=%0d",
                 $time, out_valid, aluA, aluB, alufun, m_v, m.a, m.b, m.f);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    @(negedge clk);
    rst = r; in_valid = v; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;

    // Reset wins over a simultaneous valid OPq.
    step(1, 1, 4'h6, 4'h1, 64'd5, 64'd12, 64'd0);
    step(1, 1, 4'h6, 4'h1, 64'd5, 64'd12, 64'd0);
    chk("rst_valid", W'(out_valid), 0);
    chk("rst_aluA", aluA, 0);
    chk("rst_aluB", aluB, 0);
    chk("rst_alufun", W'(alufun), 0);

    step(0, 1, 4'h6, 4'h1, 64'd5, 64'd12, 64'd77);
    chk("opq_valid", W'(out_valid), 1);
    chk("opq_aluA", aluA, 64'd5);
    chk("opq_aluB", aluB, 64'd12);
    chk("opq_alufun", W'(alufun), 1);

    step(0, 1, 4'hA, 4'h0, 64'h55, 64'h100, 64'h66);
    chk("push_aluA", aluA, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("push_aluB", aluB, 64'h100);
    chk("push_alufun", W'(alufun), 0);
    step(0, 1, 4'hB, 4'h0, 64'h55, 64'h100, 64'h66);
    chk("pop_aluA", aluA, 64'd8);
    chk("pop_aluB", aluB, 64'h100);

    step(0, 1, 4'h3, 4'h0, 64'h11, 64'h99, 64'h1234);
    chk("irmov_aluA", aluA, 64'h1234);
    chk("irmov_aluB", aluB, 0);
    step(0, 1, 4'h5, 4'h0, 64'h11, 64'h200, 64'd16);
    chk("mrmov_aluA", aluA, 64'd16);
    chk("mrmov_aluB", aluB, 64'h200);

    // Hold: valid xor, then idle cycles carrying a different icode.
    step(0, 1, 4'h6, 4'h3, 64'hA, 64'hB, 64'hC);
    chk("xor_alufun", W'(alufun), 3);
    step(0, 0, 4'h8, 4'h0, 64'h1, 64'h2, 64'h3);
    chk("hold_valid", W'(out_valid), 0);
    chk("hold_alufun", W'(alufun), 3);
    chk("hold_aluA", aluA, 64'hA);
    step(0, 0, 4'h8, 4'h0, 64'h1, 64'h2, 64'h3);
    step(0, 0, 4'h8, 4'h0, 64'h1, 64'h2, 64'h3);
    chk("hold3_aluB", aluB, 64'hB);

    step(0, 1, 4'h6, 4'h7, 64'h1, 64'h2, 64'h3);
    chk("opq_ifun7", W'(alufun), 3);
    step(0, 1, 4'h6, 4'hE, 64'h1, 64'h2, 64'h3);
    chk("opq_ifunE", W'(alufun), 2);
    step(0, 1, 4'h2, 4'h3, 64'hDEAD, 64'hBEEF, 64'h3);
    chk("rrmov_aluA", aluA, 64'hDEAD);
    chk("rrmov_aluB", aluB, 0);
    step(0, 1, 4'h0, 4'h0, 64'h1, 64'h2, 64'h3);
    chk("halt_aluA", aluA, 0);

    step(0, 1, 4'hC, 4'h5, 64'h1, 64'd3, 64'd7);
`ifdef ALU_SEL_IADDQ_EN
    chk("iaddq_aluA", aluA, 64'd7);
    chk("iaddq_aluB", aluB, 64'd3);
`else
    chk("iaddq_aluA", aluA, 0);
    chk("iaddq_aluB", aluB, 0);
`endif
    chk("iaddq_alufun", W'(alufun), 0);

    // Mid-stream reset discards the valid input, then first valid lands a cycle later.
    step(1, 1, 4'h4, 4'h0, 64'h1, 64'h2, 64'h3);
    chk("rst2_aluB", aluB, 0);
    step(0, 1, 4'h4, 4'h0, 64'h1, 64'h2, 64'h3);
    chk("post_rst_valid", W'(out_valid), 1);
    chk("rmmov_aluA", aluA, 64'h3);

    // Every icode back-to-back with assorted data; the model checks each cycle.
    for (int i = 0; i < 48; i++) begin
      step(0, (i % 5) != 4, 4'(i), 4'(i * 7), {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom});
    end
    step(0, 0, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_select.md
ALU_OPERAND_SELECT -- requirements
Module: alu_operand_select

Interface
REQ-001 Parameter: DATA_W, default 64, ALU operand width; all data ports sized DATA_W.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  icode/ifun/valA/valB/valC valid this cycle.
REQ-005 Port: icode  input  4  Y86 instruction code.
REQ-006 Port: ifun  input  4  Y86 function code.
REQ-007 Port: valA  input  DATA_W  register-file read A.
REQ-008 Port: valB  input  DATA_W  register-file read B.
REQ-009 Port: valC  input  DATA_W  instruction constant.
REQ-010 Port: out_valid  output  1  registered aluA/aluB/alufun valid.
REQ-011 Port: aluA  output  DATA_W  ALU operand A.
REQ-012 Port: aluB  output  DATA_W  ALU operand B.
REQ-013 Port: alufun  output  2  ALU op: 0 add, 1 sub, 2 and, 3 xor.

Function
REQ-014 aluA selection SHALL be: icode 2 (rrmovq/cmovXX) or 6 (OPq) -> valA; icode 3 (irmovq), 4 (rmmovq), 5 (mrmovq) -> valC; icode 8 (call) or 0xA (pushq) -> -8 (two's complement, all bits of DATA_W); icode 9 (ret) or 0xB (popq) -> +8; all other icodes -> 0.
REQ-015 aluB selection SHALL be: icode 4, 5, 6, 8, 9, 0xA, 0xB -> valB; icode 2, 3 and all other icodes -> 0.
REQ-016 alufun SHALL be ifun[1:0] when icode = 6, otherwise 0 (add).
REQ-017 icode = 6 with ifun > 3 SHALL still use ifun[1:0]; no error reported.
REQ-018 Selection is combinational; results SHALL be registered, one-cycle latency: inputs sampled at edge N appear on outputs after edge N.
REQ-019 Output registers SHALL load only when in_valid = 1; when in_valid = 0 they SHALL hold previous values.
REQ-020 out_valid SHALL equal in_valid registered (1 after any edge with in_valid = 1, 0 after any edge with in_valid = 0).
REQ-021 Back-to-back valid inputs SHALL produce back-to-back outputs, one result per cycle, no bubbles.
REQ-022 ±8 constants SHALL be sign/zero-extended to full DATA_W; no arithmetic performed in this block.

Reset
REQ-023 When rst = 1 at a rising edge: aluA = 0, aluB = 0, alufun = 0, out_valid = 0, regardless of in_valid.
REQ-024 rst SHALL override a simultaneous in_valid = 1; that input is discarded.
REQ-025 First valid input after rst deasserts SHALL appear one cycle later with out_valid = 1.

Configuration
REQ-026 Macro ALU_SEL_IADDQ_EN: when defined, icode 0xC (iaddq) SHALL select aluA = valC, aluB = valB, alufun = 0 (add).
REQ-027 When ALU_SEL_IADDQ_EN is undefined, icode 0xC SHALL fall into the default: aluA = 0, aluB = 0, alufun = 0.

Verification
REQ-028 rst=1 with in_valid=1, icode=6 -> after edge: aluA=0, aluB=0, alufun=0, out_valid=0.
REQ-029 in_valid=1, icode=6, ifun=1, valA=5, valB=12 -> next cycle aluA=5, aluB=12, alufun=1, out_valid=1.
REQ-030 icode=0xA, valB=0x100 -> aluA=0xFFFF_FFFF_FFFF_FFF8, aluB=0x100, alufun=0; icode=0xB, valB=0x100 -> aluA=8, aluB=0x100.
REQ-031 icode=3, valC=0x1234, valB=0x99 -> aluA=0x1234, aluB=0, alufun=0; icode=5, valC=16, valB=0x200 -> aluA=16, aluB=0x200.
REQ-032 Valid icode=6/ifun=3 then in_valid=0 with icode=8 for 3 cycles -> outputs hold alufun=3, out_valid=0 after first idle edge.
REQ-033 icode=0xC, valC=7, valB=3: with ALU_SEL_IADDQ_EN -> aluA=7, aluB=3, alufun=0; without -> aluA=0, aluB=0, alufun=0.
